fft_ctrl_in: RTL

FFT_CTRL_IN -- requirements
Module: fft_ctrl_in

---
 rtl/fft_ctrl_pkg.sv | 25 ++
 rtl/fft_ctrl_skid_fifo.sv | 47 ++++
 rtl/fft_ctrl_in.sv | 111 +++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT input controller: FSM encodings,
// skid FIFO geometry and the {real, imag} word packing.
package fft_ctrl_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STREAM   = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_WAIT_OUT = 2'd3;

  // Skid FIFO: 4 entries, 2-bit pointers, 3-bit occupancy (0..4)
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_CW    = 3;

  // A RAM word carries two parts, real in the upper half, imag in the lower
  localparam int CPLX_PARTS = 2;

  // A read may be issued only if its data is guaranteed a FIFO slot
  function automatic logic can_issue(input logic [FIFO_CW-1:0] occ,
                                     input logic [FIFO_CW-1:0] inflight);
    return ({1'b0, occ} + {1'b0, inflight}) < 4'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/fft_ctrl_skid_fifo.sv
// 4-entry skid FIFO between the sample RAM read pipeline and the FFT sink.
// No write-to-read bypass: a word written into an empty FIFO is visible
// on the following cycle.
module fft_ctrl_skid_fifo
  import fft_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  output logic [W-1:0]       rd_data,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  logic [W-1:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic                 do_wr, do_rd;

  // Writer never exceeds capacity because reads are only issued with a free
  // slot reserved; the full guard just keeps the storage consistent.
  assign do_wr   = wr_en && (count != FIFO_CW'(FIFO_DEPTH));
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + FIFO_CW'(do_wr) - FIFO_CW'(do_rd);
    end
  end

endmodule

// File: rtl/fft_ctrl_in.sv
// FFT input controller: streams one 2^ADDR_WIDTH-point frame from the
// sample RAM into the FFT sink with backpressure, then waits for the
// FFT to emit its output eop before reporting done.
module fft_ctrl_in
  import fft_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           inverse_in,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic [CPLX_PARTS*DATA_WIDTH-1:0] rd_data,
  output logic                           sink_valid,
  output logic                           sink_sop,
  output logic                           sink_eop,
  input  logic                           sink_ready,
  output logic [DATA_WIDTH-1:0]          sink_real,
  output logic [DATA_WIDTH-1:0]          sink_imag,
  output logic [1:0]                     sink_error,
  output logic                           sink_inverse,
  input  logic                           src_eop_valid
);

  localparam int                  WW   = CPLX_PARTS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] beat;
  // vld_pipe[k] marks a read issued k cycles ago; bit RD_LAT lines up with rd_data
  logic [RD_LAT:1]       vld_pipe;
  logic [FIFO_CW-1:0]    inflight;
  logic [FIFO_CW-1:0]    fifo_cnt;
  logic                  fifo_empty;
  logic [WW-1:0]         fifo_head;
  logic                  issue, xfer;

  assign inflight = FIFO_CW'($countones(vld_pipe));
  assign issue    = (state == ST_STREAM) && can_issue(fifo_cnt, inflight);
  assign xfer     = sink_valid && sink_ready;

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_WAIT_OUT) && src_eop_valid;
  assign rd_addr    = rd_idx;
  assign sink_valid = !fifo_empty;
  assign sink_sop   = sink_valid && (beat == '0);
  assign sink_eop   = sink_valid && (beat == LAST);
  assign sink_real  = sink_valid ? fifo_head[WW-1:DATA_WIDTH] : '0;
  assign sink_imag  = sink_valid ? fifo_head[DATA_WIDTH-1:0]  : '0;
  assign sink_error = 2'b00;

  // Frame sequencing and read address generation
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_IDLE;
      rd_idx       <= '0;
      sink_inverse <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state        <= ST_STREAM;
          rd_idx       <= '0;
          sink_inverse <= inverse_in;
        end
        // Address holds at LAST after the final read instead of wrapping
        ST_STREAM: if (issue) begin
          if (rd_idx == LAST) state  <= ST_DRAIN;
          else                rd_idx <= rd_idx + 1'b1;
        end
        ST_DRAIN:    if (xfer && sink_eop) state <= ST_WAIT_OUT;
        ST_WAIT_OUT: if (src_eop_valid)    state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Read-latency tracker: a token per issued read, retired on FIFO write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Output beat counter for sop/eop framing; restarts on every new frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                               beat <= '0;
    else if ((state == ST_IDLE) && start)  beat <= '0;
    else if (xfer)                         beat <= beat + 1'b1;
  end

  fft_ctrl_skid_fifo #(.W(WW)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (vld_pipe[RD_LAT]),
    .wr_data (rd_data),
    .rd_en   (sink_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule
